// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Multiplexed 4-digit hex display and PC LED driver behind the TSC CPU.
//   The displayed value is snapshotted only at frame boundaries so a value
//   that changes mid-scan can never show as a mix of old and new digits.
//
// Ports
//   clk           in   system clock (shared with the CPU)
//   reset_cpu     in   synchronous active-high reset
//   output_port   in   16-bit value to display
//   PC_below8bit  in   CPU PC low byte
//   blank_lz      in   1 = blank leading-zero digits
//   freeze        in   1 = keep the current snapshot at frame boundaries
//   seg           out  segments {g,f,e,d,c,b,a}, bit0 = a
//   dp            out  decimal point (frozen indicator on digit 0)
//   an            out  digit anodes, an[0] = rightmost digit
//   led           out  registered copy of PC_below8bit
//   frame_tick    out  one-cycle pulse in the cycle after a frame boundary
module seg7_scan_display #(
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        reset_cpu,
    input  logic [15:0] output_port,
    input  logic [7:0]  PC_below8bit,
    input  logic        blank_lz,
    input  logic        freeze,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [7:0]  led,
    output logic        frame_tick
);

    localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic            SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic            AN_LOW  = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]      SEG_OFF = SEG_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]      AN_OFF  = AN_LOW ? 4'hF : 4'h0;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       d;
    logic [15:0]      snap;
    logic             tick;
    logic             boundary;
    logic [3:0]       nib;
    logic             blank;
    logic [6:0]       seg_on;
    logic [3:0]       an_on;
    logic             dp_on;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (d == 2'd3);

    // A digit is a leading zero when it and every more significant nibble
    // are zero; digit 0 always shows so an all-zero value still reads "0".
    always_comb begin
        nib   = snap[3:0];
        blank = 1'b0;
        case (d)
            2'd0: begin
                nib   = snap[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = snap[7:4];
                blank = blank_lz && (snap[15:4] == 12'h000);
            end
            2'd2: begin
                nib   = snap[11:8];
                blank = blank_lz && (snap[15:8] == 8'h00);
            end
            default: begin
                nib   = snap[15:12];
                blank = blank_lz && (snap[15:12] == 4'h0);
            end
        endcase
    end

    assign seg_on = blank ? 7'h00 : hex_to_seg(nib);
    assign an_on  = 4'b0001 << d;
    assign dp_on  = (d == 2'd0) && freeze;

    // seg, an and dp all load from the same d on the same edge, so the
    // anode and its segment pattern always switch together.
    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            cnt        <= '0;
            d          <= 2'd0;
            snap       <= 16'h0000;
            led        <= 8'h00;
            frame_tick <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            dp         <= SEG_LOW;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                d <= d + 2'd1;
            // d wraps to 0 on this same edge, so the new snapshot is first
            // shown on digit 0 of the next frame.
            if (boundary && !freeze)
                snap <= output_port;
            frame_tick <= boundary;
            led        <= PC_below8bit;
            seg        <= SEG_LOW ? ~seg_on : seg_on;
            an         <= AN_LOW ? ~an_on : an_on;
            dp         <= SEG_LOW ? ~dp_on : dp_on;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset_cpu;
    logic [15:0] output_port;
    logic [7:0]  PC_below8bit;
    logic        blank_lz;
    logic        freeze;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [7:0]  led;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .SCAN_DIV(SCAN_DIV),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset_cpu(reset_cpu),
        .output_port(output_port),
        .PC_below8bit(PC_below8bit),
        .blank_lz(blank_lz),
        .freeze(freeze),
        .seg(seg),
        .dp(dp),
        .an(an),
        .led(led),
        .frame_tick(frame_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles since reset release and the snapshot value.
    int          k;
    logic [15:0] m_snap;
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare every output 1 time unit after the edge.
    task automatic step();
        int         digit;
        logic [3:0] nib;
        logic       blank;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dp;
        logic       e_ft;
        logic [7:0] e_led;
        @(posedge clk);
        if (reset_cpu) begin
            k      = 0;
            m_snap = 16'h0000;
            e_an   = 4'hF;
            e_seg  = 7'h7F;
            e_dp   = 1'b1;
            e_ft   = 1'b0;
            e_led  = 8'h00;
        end else begin
            k++;
            digit = ((k - 1) / SCAN_DIV) % 4;
            nib   = 4'((m_snap >> (4 * digit)) & 16'h000F);
            blank = blank_lz && (digit != 0) && ((m_snap >> (4 * digit)) == 16'h0000);
            e_seg = blank ? 7'h7F : ~hex_tab[nib];
            e_an  = ~(4'b0001 << digit);
            e_dp  = !((digit == 0) && freeze);
            e_ft  = (k % FRAME == 0);
            e_led = PC_below8bit;
            if ((k % FRAME == 0) && !freeze)
                m_snap = output_port;
        end
        #1;
        check("an", {12'h000, an}, {12'h000, e_an});
        check("seg", {9'h000, seg}, {9'h000, e_seg});
        check("dp", {15'h0000, dp}, {15'h0000, e_dp});
        check("frame_tick", {15'h0000, frame_tick}, {15'h0000, e_ft});
        check("led", {8'h00, led}, {8'h00, e_led});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            PC_below8bit = 8'($urandom);
            step();
        end
    endtask

    logic [6:0] plan1_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] plan1_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        k            = 0;
        m_snap       = 16'h0000;
        reset_cpu    = 1'b1;
        output_port  = 16'h1234;
        PC_below8bit = 8'h00;
        blank_lz     = 1'b0;
        freeze       = 1'b0;
        step();
        step();
        reset_cpu = 1'b0;

        // First frame shows 0000, then 1234 scanned digit 0..3.
        run(FRAME);
        for (int i = 0; i < FRAME; i++) begin
            step();
            check("plan1_seg", {9'h000, seg}, {9'h000, plan1_seg[i / SCAN_DIV]});
            check("plan1_an", {12'h000, an}, {12'h000, plan1_an[i / SCAN_DIV]});
        end

        // Leading-zero blanking on several snapshot values.
        blank_lz    = 1'b1;
        output_port = 16'h0005;
        run(2 * FRAME);
        output_port = 16'h0000;
        run(2 * FRAME);
        output_port = 16'h0100;
        run(2 * FRAME);
        output_port = 16'h0030;
        run(2 * FRAME);

        // Freeze holds 1234 while the port moves to ABCD.
        blank_lz    = 1'b0;
        output_port = 16'h1234;
        run(2 * FRAME);
        freeze      = 1'b1;
        output_port = 16'hABCD;
        run(3 * FRAME);
        freeze = 1'b0;
        run(2 * FRAME);

        // Mid-frame change of the port does not tear the display.
        output_port = 16'h1111;
        run(2 * FRAME);
        run(SCAN_DIV + 2);
        output_port = 16'h2222;
        run(2 * FRAME);

        // LED follows the PC byte with one cycle of latency.
        PC_below8bit = 8'h2C;
        step();
        PC_below8bit = 8'h2D;
        step();

        // Reset pulse while digit 2 is being scanned.
        while (((k / SCAN_DIV) % 4) != 2)
            run(1);
        reset_cpu = 1'b1;
        step();
        reset_cpu = 1'b0;
        run(2 * FRAME + 3);

        // Randomized traffic, including occasional resets and freezes.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] mask;
            reset_cpu = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: mask = 16'hFFFF;
                    1: mask = 16'h0FFF;
                    2: mask = 16'h00FF;
                    3: mask = 16'h000F;
                    default: mask = 16'h0000;
                endcase
                output_port = 16'($urandom) & mask;
            end
            if ($urandom_range(0, 39) == 0)
                freeze = ~freeze;
            if ($urandom_range(0, 29) == 0)
                blank_lz = ~blank_lz;
            run(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Output stage directly downstream of the TSC CPU.
- Consumes the CPU's 16-bit output_port (WWD result or selected register) and PC_below8bit.
- Drives a 4-digit multiplexed 7-segment display (hex) and 8 PC LEDs.
- Captures the displayed value only at frame boundaries, so a value changing mid-scan never produces a torn (mixed old/new) display.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit is lit (legal range 1..2^20); benches use 4.
- SEG_ACTIVE_LOW, 1, 1 = seg and dp outputs are active-low; 0 = active-high.
- AN_ACTIVE_LOW, 1, 1 = an outputs are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock, shared with cpu.
- reset_cpu  in  1  synchronous, active-high reset.
- output_port  in  16  value to display (CPU output_port).
- PC_below8bit  in  8  CPU PC low byte.
- blank_lz  in  1  1 = blank leading-zero digits.
- freeze  in  1  1 = hold the current snapshot (no reload at frame boundary).
- seg  out  7  segments {g,f,e,d,c,b,a}; bit0 = a.
- dp  out  1  decimal point.
- an  out  4  digit anodes; an[0] = rightmost digit = snap[3:0].
- led  out  8  registered copy of PC_below8bit.
- frame_tick  out  1  one-cycle pulse marking a frame boundary.

Behaviour:
- Prescaler cnt counts 0..SCAN_DIV-1 and wraps to 0. tick = (cnt == SCAN_DIV-1). SCAN_DIV = 1 gives tick every cycle.
- Digit index d (2 bits) increments on tick and wraps 3 -> 0. One frame = 4*SCAN_DIV cycles.
- Frame boundary = tick && d == 3.
  - At a boundary, snap <= output_port if freeze == 0; otherwise snap holds.
  - frame_tick is registered: high for exactly one cycle, in the cycle after the boundary, whether or not freeze is set.
  - freeze and output_port are sampled only at the boundary. Changes mid-frame have no effect until the next boundary.
- Hex decode, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - With SEG_ACTIVE_LOW = 1 the pattern is inverted (0 -> 7'h40, 1 -> 7'h79).
- Leading-zero blanking (blank_lz = 1): digit k (k = 1..3) is blanked (all segments off) when nibbles k..3 of snap are all zero. Digit 0 is never blanked. blank_lz is evaluated combinationally against snap each cycle.
- dp is on only when d == 0 and freeze == 1 (frozen indicator); otherwise off. Polarity follows SEG_ACTIVE_LOW.
- Output registration:
  - seg, dp and an are registered from the same stage, computed from the current d and snap. They change in the same edge, so no ghosting.
  - Latency is 1 cycle from a d change.
  - Exactly one anode is active at any time after the first post-reset cycle.
- led <= PC_below8bit every cycle (1-cycle latency), independent of the scan.
- Reset (reset_cpu = 1 at a posedge), including mid-frame, sets at that edge:
  - cnt = 0, d = 0, snap = 16'h0000, led = 0, frame_tick = 0.
  - an = all inactive (4'hF when active-low), seg = all off (7'h7F when active-low), dp = off.
  - Scanning restarts from digit 0 in the first cycle after reset deasserts.
- Before the first boundary after reset, the display shows snap = 0000 (with blank_lz = 1: only digit 0 shows "0").
- All outputs are deterministic; no X after reset.

Test Plan (SCAN_DIV = 4, active-low defaults):
1. Reset, then hold output_port = 16'h1234, blank_lz = 0 -> first frame shows 0000 (seg = 7'h40 on each anode); frame_tick pulses every 16 cycles. After the first frame_tick, an cycles 1110/1101/1011/0111 for 4 cycles each with seg = 7'h19 / 7'h30 / 7'h24 / 7'h79.
2. blank_lz = 1, snap = 16'h0005 -> digits 3..1 show seg = 7'h7F, digit 0 shows 7'h12. snap = 16'h0000 -> only digit 0 shows 7'h40. snap = 16'h0100 -> digit 3 blank; digits 2..0 show 7'h79, 7'h40, 7'h40.
3. Display 16'h1234, assert freeze, change output_port to 16'hABCD -> display stays 1234 for multiple frames; dp = 0 only while an = 1110. Deassert freeze -> after the next frame_tick, digits 3..0 show 7'h08, 7'h03, 7'h46, 7'h21.
4. Change output_port from 16'h1111 to 16'h2222 while d = 1 (freeze = 0) -> remaining digits of that frame still show "1" (7'h79); "2" (7'h24) appears on all digits starting with the frame after the boundary.
5. PC_below8bit = 8'h2C, then 8'h2D one cycle later -> led = 8'h2C and 8'h2D on consecutive cycles, each one cycle after its input, independent of scan state.
6. Assert reset_cpu for 1 cycle while d = 2 -> next cycle an = 4'hF, seg = 7'h7F, dp = 1, led = 8'h00, frame_tick = 0. The following cycles restart at an = 1110 with snap = 0, and the next frame_tick occurs 16 cycles after reset deassertion.
